// File: rtl/sim_run_ctrl.sv
// Run-sequencing controller between the simulation top and the DUT.
// Sequences DUT reset, difftest init and stepping, and buffers DUT UART bytes for the host.
module sim_run_ctrl #(
   parameter int unsigned RESET_CYCLES = 100,
   parameter int unsigned INIT_TIMEOUT = 1024,
   parameter int unsigned CNT_W        = 64,
   parameter int unsigned UART_DEPTH   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CNT_W-1:0] cfg_max_cycles,
   input  logic [CNT_W-1:0] cfg_log_begin,
   input  logic [CNT_W-1:0] cfg_log_end,
   output logic             dut_reset,
   output logic             init_req,
   input  logic             init_ack,
   output logic             step_valid,
   input  logic             step_stop,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             log_enable,
   output logic             finish,
   output logic [1:0]       finish_code,
   input  logic             dut_uart_valid,
   input  logic [7:0]       dut_uart_ch,
   output logic             host_uart_valid,
   output logic [7:0]       host_uart_ch,
   input  logic             host_uart_ready,
   output logic [7:0]       uart_drop_cnt
);

   localparam int unsigned PTR_W = $clog2(UART_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = 1;
   localparam logic [PTR_W:0]   FIFO_ONE  = 1;
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(UART_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [15:0]      HOLD_LAST = 16'(RESET_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_INIT,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [15:0]      hold_cnt_reg, hold_cnt_next;
   logic [31:0]      init_cnt_reg, init_cnt_next;
   logic [CNT_W-1:0] cycle_cnt_reg, cycle_cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   logic [1:0]       finish_code_reg, finish_code_next;
   logic             dut_reset_reg, init_req_reg, step_valid_reg, finish_reg;
   logic             log_enable_reg, log_enable_next;

   // ---------------- sequencing FSM ----------------
   always_comb begin
      state_next       = state_reg;
      hold_cnt_next    = '0;
      init_cnt_next    = '0;
      cycle_cnt_next   = cycle_cnt_reg;
      finish_code_next = finish_code_reg;
      // Wrapping sum on purpose: a limit at or below the current count can never match.
      cnt_inc          = cycle_cnt_reg + CNT_ONE;
      case (state_reg)
         ST_HOLD: begin
            if (hold_cnt_reg == HOLD_LAST) begin
               state_next = ST_INIT;
            end else begin
               hold_cnt_next = hold_cnt_reg + 16'd1;
            end
         end
         ST_INIT: begin
            if (init_ack) begin
               state_next = ST_RUN;
            end else if ((INIT_TIMEOUT != 0) && (init_cnt_reg == INIT_TIMEOUT - 1)) begin
               state_next       = ST_DONE;
               finish_code_next = 2'd3;
            end else begin
               init_cnt_next = init_cnt_reg + 32'd1;
            end
         end
         ST_RUN: begin
            cycle_cnt_next = (&cycle_cnt_reg) ? cycle_cnt_reg : cnt_inc;
            if (step_stop) begin
               state_next       = ST_DONE;
               finish_code_next = 2'd1;
            end else if ((cfg_max_cycles != '0) && (cnt_inc == cfg_max_cycles)) begin
               state_next       = ST_DONE;
               finish_code_next = 2'd2;
            end
         end
         ST_DONE: begin
            state_next = ST_DONE;
         end
         default: begin
            state_next = ST_HOLD;
         end
      endcase
      // Computed on the next count so the flag lines up with the cycle_cnt being shown.
      log_enable_next = (state_next == ST_RUN) && (cfg_log_end != '0) &&
                        (cfg_log_begin <= cycle_cnt_next) && (cycle_cnt_next <= cfg_log_end);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= ST_HOLD;
         hold_cnt_reg    <= '0;
         init_cnt_reg    <= '0;
         cycle_cnt_reg   <= '0;
         finish_code_reg <= 2'd0;
         dut_reset_reg   <= 1'b1;
         init_req_reg    <= 1'b0;
         step_valid_reg  <= 1'b0;
         finish_reg      <= 1'b0;
         log_enable_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         hold_cnt_reg    <= hold_cnt_next;
         init_cnt_reg    <= init_cnt_next;
         cycle_cnt_reg   <= cycle_cnt_next;
         finish_code_reg <= finish_code_next;
         dut_reset_reg   <= (state_next == ST_HOLD);
         init_req_reg    <= (state_next == ST_INIT);
         step_valid_reg  <= (state_next == ST_RUN);
         finish_reg      <= (state_next == ST_DONE);
         log_enable_reg  <= log_enable_next;
      end
   end

   // ---------------- UART byte FIFO ----------------
   logic [7:0]       mem_reg [UART_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
   logic [PTR_W:0]   fifo_cnt_reg, fifo_cnt_next, fifo_cnt_pop;
   logic             host_valid_reg, host_valid_next;
   logic [7:0]       host_ch_reg, host_ch_next;
   logic [7:0]       drop_cnt_reg, drop_cnt_next;
   logic             push_req, push_ok, pop, full;

   always_comb begin
      push_req     = dut_uart_valid && !dut_reset_reg;
      pop          = host_valid_reg && host_uart_ready;
      full         = (fifo_cnt_reg == FIFO_FULL);
      push_ok      = push_req && (!full || pop);
      fifo_cnt_pop = pop ? (fifo_cnt_reg - FIFO_ONE) : fifo_cnt_reg;
      fifo_cnt_next = push_ok ? (fifo_cnt_pop + FIFO_ONE) : fifo_cnt_pop;
      rd_ptr_next  = pop ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
      wr_ptr_next  = push_ok ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
      host_valid_next = (fifo_cnt_next != '0);
      // The head register is loaded straight from the input when the byte lands in an empty FIFO.
      host_ch_next = host_ch_reg;
      if (push_ok && (fifo_cnt_pop == '0)) begin
         host_ch_next = dut_uart_ch;
      end else if (fifo_cnt_pop != '0) begin
         host_ch_next = mem_reg[rd_ptr_next];
      end
      drop_cnt_next = drop_cnt_reg;
      if (push_req && full && !pop && (drop_cnt_reg != 8'hFF)) begin
         drop_cnt_next = drop_cnt_reg + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= dut_uart_ch;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_cnt_reg   <= '0;
         host_valid_reg <= 1'b0;
         host_ch_reg    <= 8'd0;
         drop_cnt_reg   <= 8'd0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         fifo_cnt_reg   <= fifo_cnt_next;
         host_valid_reg <= host_valid_next;
         host_ch_reg    <= host_ch_next;
         drop_cnt_reg   <= drop_cnt_next;
      end
   end

   assign dut_reset       = dut_reset_reg;
   assign init_req        = init_req_reg;
   assign step_valid      = step_valid_reg;
   assign cycle_cnt       = cycle_cnt_reg;
   assign log_enable      = log_enable_reg;
   assign finish          = finish_reg;
   assign finish_code     = finish_code_reg;
   assign host_uart_valid = host_valid_reg;
   assign host_uart_ch    = host_ch_reg;
   assign uart_drop_cnt   = drop_cnt_reg;

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Run-sequencing controller between the simulation top and the DUT (SimTop).
- Holds the DUT in reset for a fixed count, performs a one-time difftest init handshake, then issues one step request per cycle.
- Enforces the max-cycle limit, derives the log window enable, and buffers DUT UART bytes toward the host printer.
- Replaces ad-hoc sequencing in the testbench with one checkable FSM.

Parameters:
- RESET_CYCLES, 100, clock cycles dut_reset stays high after controller reset release (1..2^16-1).
- INIT_TIMEOUT, 1024, cycles to wait for init_ack before aborting (0 = no timeout).
- CNT_W, 64, width of cycle counter, log bounds and max-cycle limit.
- UART_DEPTH, 4, UART byte FIFO entries (power of two, >=2).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset of this block
- cfg_max_cycles  in  CNT_W  run limit; 0 = unlimited; sampled every cycle
- cfg_log_begin  in  CNT_W  first cycle_cnt with logging on
- cfg_log_end  in  CNT_W  last cycle_cnt with logging on; 0 = logging disabled
- dut_reset  out  1  active-high reset to DUT
- init_req  out  1  difftest init request, level, held until ack
- init_ack  in  1  init complete
- step_valid  out  1  request one difftest step this cycle
- step_stop  in  1  step result nonzero (trap/mismatch), valid only when step_valid=1
- cycle_cnt  out  CNT_W  RUN cycles completed
- log_enable  out  1  logging window active
- finish  out  1  sticky run-complete flag
- finish_code  out  2  0 none, 1 step_stop, 2 max cycles, 3 init timeout
- dut_uart_valid  in  1  DUT UART byte strobe
- dut_uart_ch  in  8  DUT UART byte
- host_uart_valid  out  1  FIFO head valid
- host_uart_ch  out  8  FIFO head byte
- host_uart_ready  in  1  host consumes head when valid&ready
- uart_drop_cnt  out  8  bytes dropped on full FIFO, saturating at 255

Behaviour:
- Reset (reset=0, async): state HOLD, dut_reset=1, init_req=0, step_valid=0, cycle_cnt=0, log_enable=0, finish=0, finish_code=0, FIFO empty, host_uart_valid=0, host_uart_ch=0, uart_drop_cnt=0.
- All outputs are registered.
- States: HOLD -> INIT -> RUN -> DONE; DONE is terminal until reset.
- HOLD:
  - dut_reset=1; an internal counter runs from 0.
  - dut_reset deasserts on the clock edge after RESET_CYCLES full cycles; the same edge enters INIT.
- INIT:
  - dut_reset=0, init_req=1.
  - Leave to RUN on the edge where init_ack=1; init_req is 0 in the first RUN cycle.
  - If INIT_TIMEOUT!=0 and INIT_TIMEOUT cycles elapse without ack: go to DONE, finish_code=3.
  - init_ack outside INIT is ignored.
- RUN:
  - step_valid=1 every cycle.
  - Each RUN cycle, cycle_cnt increments on the following edge; saturates at all-ones.
  - step_stop=1 -> DONE with code 1.
  - Else if cfg_max_cycles!=0 and cycle_cnt+1 == cfg_max_cycles -> DONE with code 2, so exactly cfg_max_cycles steps are issued.
  - Both conditions in the same cycle -> code 1.
  - cfg_max_cycles changed to a value <= cycle_cnt mid-run: never matches; the run continues.
- DONE:
  - finish=1, step_valid=0, dut_reset=0; cycle_cnt frozen; finish_code frozen.
- log_enable is registered: next value = (next-state==RUN) && cfg_log_end!=0 && cfg_log_begin <= next cycle_cnt <= cfg_log_end. It is therefore aligned with the cycle_cnt value shown.
- UART FIFO:
  - Push when dut_uart_valid=1 and dut_reset=0. DUT bytes during HOLD are discarded without counting.
  - Pop on host_uart_valid & host_uart_ready.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no drop.
  - Push while full without pop: byte discarded, uart_drop_cnt+1, saturating.
  - Push into empty FIFO: host_uart_valid=1 the next cycle (1-cycle latency); no bypass.
  - FIFO keeps draining in DONE.
  - host_uart_ch holds its value when invalid.
- Reset asserted mid-run: everything returns to reset values immediately. FIFO contents are lost.

Test Plan:
- RESET_CYCLES=4, init_ack at 3rd INIT cycle, cfg_max_cycles=10 -> dut_reset high exactly 4 cycles; init_req high 3 cycles; step_valid high 10 cycles; finish=1, finish_code=2, cycle_cnt=10.
- cfg_max_cycles=0, step_stop pulsed with step_valid at cycle_cnt=7 -> DONE, finish_code=1, cycle_cnt=8, step_valid=0 after; step_stop at cycle_cnt=9 with cfg_max_cycles=10 -> code 1, not 2.
- INIT_TIMEOUT=16, init_ack never asserted -> after 16 INIT cycles finish=1, finish_code=3, step_valid never asserted.
- cfg_log_begin=3, cfg_log_end=5, max 10 -> log_enable high exactly while cycle_cnt is 3,4,5; cfg_log_end=0 -> log_enable never high.
- UART: host_uart_ready=0, 6 bytes 0x41..0x46 pushed in RUN -> FIFO holds 0x41..0x44, uart_drop_cnt=2; ready=1 -> drains 0x41,0x42,0x43,0x44 in order; push+pop while full -> no drop.
- Assert reset mid-RUN at cycle_cnt=5 with FIFO non-empty -> all outputs at reset values the same cycle; after release, the full HOLD/INIT sequence repeats.
